// File: rtl/rr_mux4_arbiter_if.sv
// Requester/consumer bundle for the 4-way round-robin arbiter.
// master = arbiter side, slave = producers/consumer side.
interface rr_mux4_arbiter_if #(
  parameter int unsigned DW = 4
);
  logic [3:0]    req_valid;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] c;
  logic [DW-1:0] d;
  logic [3:0]    req_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          s1;
  logic          s0;
  logic          busy;

  modport master (
    input  req_valid, a, b, c, d, out_ready,
    output req_ready, out_valid, out_data, s1, s0, busy
  );

  modport slave (
    output req_valid, a, b, c, d, out_ready,
    input  req_ready, out_valid, out_data, s1, s0, busy
  );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter/sequencer sharing one DW-bit channel among requesters A..D.
// Optional owner-burst mode is enabled by defining ARB_BURST_EN.
module rr_mux4_arbiter #(
  parameter int unsigned DW        = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_mux4_arbiter_if.master  bus
);

  typedef enum logic {IDLE, SEND} state_t;

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("MAX_BURST must be in 1..15");
  end

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    sel_q, sel_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;

`ifdef ARB_BURST_EN
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
  logic [3:0] burst_q, burst_d;
`endif

  logic          win_found;
  logic [1:0]    win_idx;
  logic [1:0]    scan_idx;
  logic [DW-1:0] win_data;
  logic          handshake;

  // Rotating priority search: the lowest offset from ptr that is valid wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = ptr_q + 2'(k);
      if (bus.req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // 4x1 data mux steered by the current winner.
  always_comb begin
    case (win_idx)
      2'd0:    win_data = bus.a;
      2'd1:    win_data = bus.b;
      2'd2:    win_data = bus.c;
      default: win_data = bus.d;
    endcase
  end

  assign handshake = valid_q & bus.out_ready;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
`ifdef ARB_BURST_EN
    burst_d = burst_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = SEND;
          sel_d   = win_idx;
          data_d  = win_data;
          valid_d = 1'b1;
          busy_d  = 1'b1;
`ifdef ARB_BURST_EN
          if (win_idx != sel_q) burst_d = 4'd0;
`endif
        end
      end
      SEND: begin
        if (handshake) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
`ifdef ARB_BURST_EN
          // Owner keeps priority until it has completed MAX_BURST beats.
          if (burst_q < BURST_LAST) begin
            ptr_d   = sel_q;
            burst_d = burst_q + 4'd1;
          end else begin
            ptr_d   = sel_q + 2'd1;
            burst_d = 4'd0;
          end
`else
          ptr_d = sel_q + 2'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ARB_BURST_EN
      burst_q <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef ARB_BURST_EN
      burst_q <= burst_d;
`endif
    end
  end

  // Accept strobe is combinational and only offered while arbitrating.
  always_comb begin
    bus.req_ready = 4'b0000;
    if (rst_n && state_q == IDLE && win_found) bus.req_ready = 4'b0001 << win_idx;
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.s1        = sel_q[1];
  assign bus.s0        = sel_q[0];
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed, table-driven bench for rr_mux4_arbiter (DW=4, MAX_BURST=4).
module tb_rr_mux4_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_mux4_arbiter_if #(.DW(4)) bus ();

  rr_mux4_arbiter #(.DW(4), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct packed {
    logic [3:0] rv;
    logic [3:0] a, b, c, d;
    logic       ordy;
    logic [3:0] rdy;
    logic       vld;
    logic [3:0] dat;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] rv, input logic [3:0] bval, input logic ordy,
                              input logic [3:0] rdy, input logic vld, input logic [3:0] dat,
                              input logic [1:0] sel, input logic bsy);
    vec_t v;
    v.rv = rv; v.a = 4'b1010; v.b = bval; v.c = 4'b1100; v.d = 4'b1110;
    v.ordy = ordy; v.rdy = rdy; v.vld = vld; v.dat = dat; v.sel = sel; v.busy = bsy;
    return v;
  endfunction

  task automatic check_outs(input string tag, input logic [3:0] rdy, input logic vld,
                            input logic [3:0] dat, input logic [1:0] sel, input logic bsy);
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'(rdy));
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'(vld));
    check({tag, " out_data"},  32'(bus.out_data),  32'(dat));
    check({tag, " sel"},       32'({bus.s1, bus.s0}), 32'(sel));
    check({tag, " busy"},      32'(bus.busy), 32'(bsy));
  endtask

  // Waits (bounded) for the next handshake and returns the transferred word.
  task automatic get_beat(input string tag, output logic [3:0] data);
    bit done = 1'b0;
    data = 4'hx;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        data = bus.out_data;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_fail++;
      $display("FAIL %s: no handshake within 20 cycles", tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [3:0] beat;
  logic [3:0] exp_seq [9];

  initial begin
    // Idle(0)->C, wrap/skip from D, idle ready-ignored, backpressure on B, then C.
    vecs[0]  = mk(4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b0, 4'b0000, 2'b00, 1'b0);
    vecs[1]  = mk(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 4'b1100, 2'b10, 1'b1);
    vecs[2]  = mk(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b1100, 2'b10, 1'b0);
    vecs[3]  = mk(4'b0101, 4'b1111, 1'b0, 4'b0001, 1'b0, 4'b1100, 2'b10, 1'b0);
    vecs[4]  = mk(4'b0101, 4'b1111, 1'b1, 4'b0000, 1'b1, 4'b1010, 2'b00, 1'b1);
    vecs[5]  = mk(4'b0101, 4'b1111, 1'b1, 4'b0100, 1'b0, 4'b1010, 2'b00, 1'b0);
    vecs[6]  = mk(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 4'b1100, 2'b10, 1'b1);
    vecs[7]  = mk(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b1100, 2'b10, 1'b0);
    vecs[8]  = mk(4'b0010, 4'b0100, 1'b0, 4'b0010, 1'b0, 4'b1100, 2'b10, 1'b0);
    for (int i = 9; i < 14; i++)
      vecs[i] = mk(4'b1111, 4'b0100, 1'b0, 4'b0000, 1'b1, 4'b0100, 2'b01, 1'b1);
    vecs[14] = mk(4'b1111, 4'b0100, 1'b1, 4'b0000, 1'b1, 4'b0100, 2'b01, 1'b1);
    vecs[15] = mk(4'b1111, 4'b0100, 1'b1, 4'b0100, 1'b0, 4'b0100, 2'b01, 1'b0);
    vecs[16] = mk(4'b1111, 4'b0100, 1'b1, 4'b0000, 1'b1, 4'b1100, 2'b10, 1'b1);

    bus.req_valid = 4'b1111;
    bus.a = 4'b1010; bus.b = 4'b1111; bus.c = 4'b1100; bus.d = 4'b1110;
    bus.out_ready = 1'b1;

    // Reset held with all requests asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0);
    rst_n = 1'b1;
    #1;
    check("first grant after reset", 32'(bus.req_ready), 32'(4'b0001));
    bus.req_valid = 4'b0000;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      bus.req_valid = vecs[i].rv;
      bus.a = vecs[i].a; bus.b = vecs[i].b; bus.c = vecs[i].c; bus.d = vecs[i].d;
      bus.out_ready = vecs[i].ordy;
      @(negedge clk);
      check_outs($sformatf("v%0d", i), vecs[i].rdy, vecs[i].vld, vecs[i].dat, vecs[i].sel, vecs[i].busy);
      @(posedge clk); #1;
    end

    // Reset while a word is pending: discard it and return ptr to A.
    bus.b = 4'b1111;
    bus.req_valid = 4'b0001;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    check("pre-reset out_valid", 32'(bus.out_valid), 32'(1'b1));
    bus.req_valid = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    check_outs("mid-send reset", 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ptr cleared by reset", 32'(bus.req_ready), 32'(4'b0001));
    bus.out_ready = 1'b1;

`ifndef ARB_BURST_EN
    exp_seq[0] = 4'b1010; exp_seq[1] = 4'b1111; exp_seq[2] = 4'b1100;
    exp_seq[3] = 4'b1110; exp_seq[4] = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      get_beat($sformatf("rr beat %0d", i), beat);
      check($sformatf("rr beat %0d", i), 32'(beat), 32'(exp_seq[i]));
    end
`else
    for (int i = 0; i < 4; i++) exp_seq[i] = 4'b1010;
    for (int i = 4; i < 8; i++) exp_seq[i] = 4'b1111;
    exp_seq[8] = 4'b1100;
    for (int i = 0; i < 9; i++) begin
      get_beat($sformatf("burst beat %0d", i), beat);
      check($sformatf("burst beat %0d", i), 32'(beat), 32'(exp_seq[i]));
    end
    bus.req_valid = 4'b0000;
    do_reset();
    bus.req_valid = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      get_beat($sformatf("owner beat %0d", i), beat);
      check($sformatf("owner beat %0d", i), 32'(beat), 32'(4'b1010));
    end
    bus.req_valid = 4'b0010;
    get_beat("after owner drop", beat);
    check("after owner drop", 32'(beat), 32'(4'b1111));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
